// File: rtl/waterfall_scroller_if.sv
// -----------------------------------------------------------------------------
// waterfall_scroller_if
// Bundles the line-source handshake and the frame-RAM write/read port of the
// waterfall frame-buffer controller.
//
//   line_valid  source -> ctrl   source presents a sample
//   line_data   source -> ctrl   sample value, column order 0..H_RES-1
//   line_ready  ctrl -> source   controller takes the sample this cycle
//   ram_addr    ctrl -> RAM      frame-RAM address (read or write)
//   ram_wdata   ctrl -> RAM      frame-RAM write data
//   ram_we      ctrl -> RAM      frame-RAM write enable
//
// Modports: master = controller side, slave = source/RAM side.
// -----------------------------------------------------------------------------
interface waterfall_scroller_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 17
);
   logic              line_valid;
   logic [DATA_W-1:0] line_data;
   logic              line_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;

   modport master (
      input  line_valid,
      input  line_data,
      output line_ready,
      output ram_addr,
      output ram_wdata,
      output ram_we
   );

   modport slave (
      output line_valid,
      output line_data,
      input  line_ready,
      input  ram_addr,
      input  ram_wdata,
      input  ram_we
   );
endinterface

// File: rtl/waterfall_scroller.sv
// -----------------------------------------------------------------------------
// waterfall_scroller
// Frame-buffer controller for the scrolling waterfall display. After reset it
// zero-fills the frame RAM, then issues registered read addresses during
// active video. Every SCROLL_DIV frames (unless frozen) it moves the ring head
// up by one physical row and accepts one new line of H_RES samples during the
// lower vertical blanking, so the newest line is always shown at y = 0.
//
// Ports:
//   clk          pixel clock, single domain
//   reset        synchronous, active-high
//   visible      active-video pixel strobe from the timing generator
//   lower_blank  high during vertical blanking after the last visible row
//   x, y         current pixel column / row
//   freeze       suppresses scroll steps (frame counting continues)
//   head         physical row currently shown at y = 0
//   clearing     high while the RAM zero-fill runs
//   overrun      sticky: a line load was cut short by the end of blanking
//   bus          line handshake and frame-RAM port (master side)
// -----------------------------------------------------------------------------
module waterfall_scroller #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int DATA_W     = 8,
   parameter int SCROLL_DIV = 4,
   parameter int ADDR_W     = $clog2(H_RES*V_RES)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       visible,
   input  logic                       lower_blank,
   input  logic [$clog2(H_RES)-1:0]   x,
   input  logic [$clog2(V_RES)-1:0]   y,
   input  logic                       freeze,
   output logic [$clog2(V_RES)-1:0]   head,
   output logic                       clearing,
   output logic                       overrun,
   waterfall_scroller_if.master       bus
);

   localparam int YW   = $clog2(V_RES);
   localparam int CW   = $clog2(H_RES + 1);
   localparam int FW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int NPIX = H_RES * V_RES;

   localparam logic [ADDR_W-1:0] LP_LAST_A = ADDR_W'(NPIX - 1);
   localparam logic [ADDR_W-1:0] LP_HRES_A = ADDR_W'(H_RES);
   localparam logic [YW:0]       LP_VRES_S = (YW+1)'(V_RES);
   localparam logic [YW-1:0]     LP_VMAX   = YW'(V_RES - 1);
   localparam logic [CW-1:0]     LP_HRES_C = CW'(H_RES);
   localparam logic [CW-1:0]     LP_HLAST  = CW'(H_RES - 1);
   localparam logic [FW-1:0]     LP_FMAX   = FW'(SCROLL_DIV - 1);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_VIDEO,
      ST_LOAD,
      ST_WAIT_BLANK
   } state_t;

   // Registered state
   state_t              r_state;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [DATA_W-1:0]   r_ram_wdata;
   logic                r_ram_we;
   logic                r_line_ready;
   logic [YW-1:0]       r_head;
   logic [FW-1:0]       r_frame;
   logic [CW-1:0]       r_col;
   logic                r_overrun;
   logic                r_clearing;
   logic                r_lb_prev;

   // Next-state values
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   w_ram_addr_nxt;
   logic [DATA_W-1:0]   w_ram_wdata_nxt;
   logic                w_ram_we_nxt;
   logic                w_line_ready_nxt;
   logic [YW-1:0]       w_head_nxt;
   logic [FW-1:0]       w_frame_nxt;
   logic [CW-1:0]       w_col_nxt;
   logic                w_overrun_nxt;
   logic                w_clearing_nxt;

   // Datapath helpers
   logic [YW:0]         w_row_sum;
   logic [YW:0]         w_row;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic                w_lb_rise;
   logic                w_line_ready;
   logic                w_hs;

   // Logical row y maps to physical row (y + head) mod V_RES. Both operands
   // are below V_RES, so one conditional subtract replaces the modulo.
   assign w_row_sum = {1'b0, y} + {1'b0, r_head};
   assign w_row     = (w_row_sum >= LP_VRES_S) ? (w_row_sum - LP_VRES_S) : w_row_sum;
   assign w_rd_addr = ADDR_W'(w_row) * LP_HRES_A + ADDR_W'(x);
   assign w_wr_addr = ADDR_W'(r_head) * LP_HRES_A + ADDR_W'(r_col);

   assign w_lb_rise = lower_blank & ~r_lb_prev;

   // The registered enable is gated by lower_blank so ready drops in the very
   // cycle blanking ends; it never looks at line_valid.
   assign w_line_ready = r_line_ready & lower_blank;
   assign w_hs         = bus.line_valid & w_line_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_ram_addr_nxt   = r_ram_addr;
      w_ram_wdata_nxt  = r_ram_wdata;
      w_ram_we_nxt     = 1'b0;
      w_line_ready_nxt = 1'b0;
      w_head_nxt       = r_head;
      w_frame_nxt      = r_frame;
      w_col_nxt        = r_col;
      w_overrun_nxt    = r_overrun;
      w_clearing_nxt   = 1'b0;

      case (r_state)
         ST_CLEAR: begin
            w_ram_wdata_nxt = '0;
            w_clearing_nxt  = 1'b1;
            // ram_we low means no clear write has been issued yet, so the
            // address register itself serves as the clear counter.
            if (!r_ram_we) begin
               w_ram_addr_nxt = '0;
               w_ram_we_nxt   = 1'b1;
            end else if (r_ram_addr == LP_LAST_A) begin
               w_ram_addr_nxt = '0;
               w_clearing_nxt = 1'b0;
               w_state_nxt    = ST_VIDEO;
            end else begin
               w_ram_addr_nxt = r_ram_addr + ADDR_W'(1);
               w_ram_we_nxt   = 1'b1;
            end
         end

         ST_VIDEO: begin
            w_ram_addr_nxt = visible ? w_rd_addr : '0;
            if (w_lb_rise) begin
               if (r_frame == LP_FMAX) begin
                  w_frame_nxt = '0;
                  if (!freeze) begin
                     // Head moves up one row so the incoming line lands at y=0
                     w_head_nxt  = (r_head == '0) ? LP_VMAX : (r_head - YW'(1));
                     w_col_nxt   = '0;
                     w_state_nxt = ST_LOAD;
                  end
               end else begin
                  w_frame_nxt = r_frame + FW'(1);
               end
            end
         end

         ST_LOAD: begin
            if (w_hs) begin
               w_ram_addr_nxt  = w_wr_addr;
               w_ram_wdata_nxt = bus.line_data;
               w_ram_we_nxt    = 1'b1;
               w_col_nxt       = r_col + CW'(1);
            end
            if (w_hs && (r_col == LP_HLAST)) begin
               w_state_nxt = ST_WAIT_BLANK;
            end else if (!lower_blank) begin
               // Blanking ended with columns missing; they keep stale data
               w_overrun_nxt = 1'b1;
               w_state_nxt   = ST_VIDEO;
            end else begin
               w_line_ready_nxt = (w_col_nxt < LP_HRES_C);
            end
         end

         ST_WAIT_BLANK: begin
            w_ram_addr_nxt = '0;
            if (!lower_blank) begin
               w_state_nxt = ST_VIDEO;
            end
         end

         default: begin
            w_state_nxt    = ST_CLEAR;
            w_clearing_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_CLEAR;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_ram_we     <= 1'b0;
         r_line_ready <= 1'b0;
         r_head       <= '0;
         r_frame      <= '0;
         r_col        <= '0;
         r_overrun    <= 1'b0;
         r_clearing   <= 1'b1;
         r_lb_prev    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ram_addr   <= w_ram_addr_nxt;
         r_ram_wdata  <= w_ram_wdata_nxt;
         r_ram_we     <= w_ram_we_nxt;
         r_line_ready <= w_line_ready_nxt;
         r_head       <= w_head_nxt;
         r_frame      <= w_frame_nxt;
         r_col        <= w_col_nxt;
         r_overrun    <= w_overrun_nxt;
         r_clearing   <= w_clearing_nxt;
         r_lb_prev    <= lower_blank;
      end
   end

   assign head           = r_head;
   assign clearing       = r_clearing;
   assign overrun        = r_overrun;
   assign bus.line_ready = w_line_ready;
   assign bus.ram_addr   = r_ram_addr;
   assign bus.ram_wdata  = r_ram_wdata;
   assign bus.ram_we     = r_ram_we;

endmodule

// File: tb/tb_waterfall_scroller.sv
// -----------------------------------------------------------------------------
// tb_waterfall_scroller
// Drives a small display (8x4, scroll every 2 frames) through directed and
// randomized frames. A behavioural model keeps the expected picture as a list
// of logical rows (row 0 = newest line) plus the expected head, frame count
// and overrun flag; a RAM model attached to the DUT's RAM port is read back
// through the DUT's own read addresses to compare against that picture.
// -----------------------------------------------------------------------------
module tb_waterfall_scroller;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int DW = 8;
   localparam int SD = 2;
   localparam int AW = $clog2(H*V);
   localparam int XW = $clog2(H);
   localparam int YW = $clog2(V);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          visible = 1'b0;
   logic          lower_blank = 1'b0;
   logic          freeze = 1'b0;
   logic [XW-1:0] px = '0;
   logic [YW-1:0] py = '0;
   logic [YW-1:0] head;
   logic          clearing;
   logic          overrun;

   waterfall_scroller_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   waterfall_scroller #(
      .H_RES(H), .V_RES(V), .DATA_W(DW), .SCROLL_DIV(SD), .ADDR_W(AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .visible(visible),
      .lower_blank(lower_blank),
      .x(px),
      .y(py),
      .freeze(freeze),
      .head(head),
      .clearing(clearing),
      .overrun(overrun),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Frame RAM attached to the controller; pre-filled with junk during reset
   logic [DW-1:0] mem [H*V];
   logic          junk_fill = 1'b0;

   always @(posedge clk) begin
      if (junk_fill) begin
         for (int i = 0; i < H*V; i++) mem[i] <= 8'hA5;
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end
   end

   // Reference model
   int m_head;
   int m_fc;
   bit m_ovr;
   int img [V][H];
   bit rst_hit;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_and_clear(input int hold);
      reset           = 1'b1;
      junk_fill       = 1'b1;
      visible         = 1'b0;
      lower_blank     = 1'b0;
      freeze          = 1'b0;
      bus.line_valid  = 1'b0;
      bus.line_data   = '0;
      repeat (hold) tick();
      chk("rst_clearing", clearing, 1);
      chk("rst_we", bus.ram_we, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_wdata", bus.ram_wdata, 0);
      chk("rst_head", head, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_ready", bus.line_ready, 0);
      reset     = 1'b0;
      junk_fill = 1'b0;
      for (int i = 0; i < H*V; i++) begin
         tick();
         chk("clr_we", bus.ram_we, 1);
         chk("clr_addr", bus.ram_addr, i);
         chk("clr_wdata", bus.ram_wdata, 0);
         chk("clr_clearing", clearing, 1);
      end
      tick();
      chk("clr_done_we", bus.ram_we, 0);
      chk("clr_done_clearing", clearing, 0);
      m_head = 0;
      m_fc   = 0;
      m_ovr  = 0;
      for (int r = 0; r < V; r++)
         for (int c = 0; c < H; c++) img[r][c] = 0;
   endtask

   // Raster over the visible area with occasional horizontal-blank cycles
   task automatic vis_phase();
      for (int yy = 0; yy < V; yy++) begin
         for (int xx = 0; xx < H; xx++) begin
            if ($urandom_range(3) == 0) begin
               visible = 1'b0;
               px = XW'($urandom_range(H-1));
               py = YW'($urandom_range(V-1));
               tick();
               chk("rd_blank_addr", bus.ram_addr, 0);
            end
            visible = 1'b1;
            px = XW'(xx);
            py = YW'(yy);
            tick();
            chk("rd_addr", bus.ram_addr, ((yy + m_head) % V) * H + xx);
            chk("rd_pix", mem[bus.ram_addr], img[yy][xx]);
         end
      end
      visible = 1'b0;
   endtask

   // Lower blanking of L cycles then a short upper blank. vmode: 0 random
   // valid, 1 always valid, 2 valid on even cycles. rst_b >= 0 aborts there.
   task automatic blank_phase(input int L, input bit frz, input int vmode,
                              input bit seqd, input int rst_b);
      bit      scroll;
      int      col;
      bit      exp_rdy;
      bit      hs;
      int      nr [H];
      logic [DW-1:0] d;

      rst_hit = 1'b0;
      freeze  = frz;
      scroll  = 1'b0;
      col     = 0;
      if (m_fc == SD-1) begin
         m_fc   = 0;
         scroll = !frz;
      end else begin
         m_fc++;
      end
      if (scroll) begin
         nr = img[V-1];
         for (int r = V-1; r > 0; r--) img[r] = img[r-1];
         img[0] = nr;
         m_head = (m_head + V - 1) % V;
      end

      for (int b = 0; b <= L; b++) begin
         if (b == rst_b) begin
            rst_hit = 1'b1;
            return;
         end
         lower_blank = (b < L);
         case (vmode)
            1:       bus.line_valid = 1'b1;
            2:       bus.line_valid = (b % 2 == 0);
            default: bus.line_valid = ($urandom_range(3) != 0);
         endcase
         d = seqd ? DW'(8'h10 + col) : DW'($urandom_range(255));
         bus.line_data = d;
         #1;
         exp_rdy = scroll && (b >= 2) && (b < L) && (col < H);
         chk("ready", bus.line_ready, exp_rdy);
         hs = bus.line_valid && exp_rdy;
         tick();
         if (b == 0) chk("head", head, m_head);
         chk("wr_we", bus.ram_we, hs);
         if (hs) begin
            chk("wr_addr", bus.ram_addr, m_head * H + col);
            chk("wr_data", bus.ram_wdata, d);
            img[0][col] = d;
            col++;
         end
      end
      if (scroll && col < H) m_ovr = 1'b1;
      chk("overrun", overrun, m_ovr);
      lower_blank    = 1'b0;
      bus.line_valid = 1'b0;
      freeze         = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ub_we", bus.ram_we, 0);
         chk("ub_addr", bus.ram_addr, 0);
      end
   endtask

   task automatic frame(input int L, input bit frz, input int vmode,
                        input bit seqd, input int rst_b);
      vis_phase();
      blank_phase(L, frz, vmode, seqd, rst_b);
   endtask

   initial begin
      bus.line_valid = 1'b0;
      bus.line_data  = '0;
      rst_hit        = 1'b0;
      reset_and_clear(3);

      // Scroll and load: second blank edge scrolls, head 0 -> 3, data 0x10..
      frame(16, 1'b0, 1, 1'b1, -1);
      frame(16, 1'b0, 1, 1'b1, -1);
      chk("head_after_load", head, m_head);

      // Freeze across four blanking periods
      for (int f = 0; f < 4; f++) frame(12, 1'b1, 1, 1'b0, -1);

      // Overrun: short blanking in a scrolling frame
      frame(12, 1'b0, 1, 1'b0, -1);
      frame(5, 1'b0, 1, 1'b0, -1);

      // Backpressure: valid toggling, sequential data
      frame(20, 1'b0, 2, 1'b1, -1);
      frame(20, 1'b0, 2, 1'b1, -1);

      // Randomized frames
      for (int f = 0; f < 14; f++) begin
         frame(($urandom_range(3) == 0) ? 5 : int'($urandom_range(20, 10)),
               ($urandom_range(3) == 0), int'($urandom_range(1)), 1'b0, -1);
      end

      // Reset in the middle of a line load
      for (int g = 0; g < 4 && m_fc != SD-1; g++) frame(14, 1'b0, 1, 1'b0, -1);
      frame(16, 1'b0, 1, 1'b1, 6);
      chk("rst_in_load_reached", rst_hit, 1);
      reset_and_clear(1);
      frame(16, 1'b0, 1, 1'b0, -1);
      frame(16, 1'b0, 0, 1'b0, -1);
      vis_phase();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

endmodule
